// File: rtl/div_pkg.sv
// Shared definitions for the multi-cycle divide sequencer.
package div_pkg;

    localparam int unsigned DIV_ITER = 32;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01,
        DONE = 2'b10
    } div_state_t;

endpackage

// File: rtl/div_datapath.sv
// Restoring-division datapath: operand capture with magnitude conversion,
// one shift/subtract step per strobe, and sign-corrected result register.
module div_datapath #(
    parameter int unsigned WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 load_i,
    input  logic                 load_dbz_i,
    input  logic                 step_i,
    input  logic                 finish_i,
    input  logic                 signed_i,
    input  logic [WIDTH-1:0]     opa_i,
    input  logic [WIDTH-1:0]     opb_i,
    output logic [2*WIDTH-1:0]   result_o
);

    logic [WIDTH-1:0]   rem_q;
    logic [WIDTH-1:0]   quo_q;
    logic [WIDTH-1:0]   div_q;
    logic               qneg_q;
    logic               rneg_q;
    logic [2*WIDTH-1:0] result_q;

    logic               opa_neg_c;
    logic               opb_neg_c;
    logic [WIDTH-1:0]   opa_abs_c;
    logic [WIDTH-1:0]   opb_abs_c;
    logic [WIDTH:0]     shift_c;
    logic               sub_ok_c;
    logic [WIDTH-1:0]   rem_d;
    logic [WIDTH-1:0]   quo_d;
    logic [WIDTH-1:0]   rem_fix_c;
    logic [WIDTH-1:0]   quo_fix_c;

    // Operand magnitudes, next shift/subtract step and its sign-fixed form.
    // The partial remainder is shifted into WIDTH+1 bits so a divisor with
    // its top bit set still compares correctly.
    always_comb begin
        opa_neg_c = signed_i & opa_i[WIDTH-1];
        opb_neg_c = signed_i & opb_i[WIDTH-1];
        opa_abs_c = opa_neg_c ? -opa_i : opa_i;
        opb_abs_c = opb_neg_c ? -opb_i : opb_i;
        shift_c   = {rem_q, quo_q[WIDTH-1]};
        sub_ok_c  = (shift_c >= {1'b0, div_q});
        rem_d     = sub_ok_c ? WIDTH'(shift_c - {1'b0, div_q}) : shift_c[WIDTH-1:0];
        quo_d     = {quo_q[WIDTH-2:0], sub_ok_c};
        rem_fix_c = rneg_q ? -rem_d : rem_d;
        quo_fix_c = qneg_q ? -quo_d : quo_d;
    end

    // Working registers and result register.
    always_ff @(posedge clk) begin
        if (rst) begin
            rem_q    <= '0;
            quo_q    <= '0;
            div_q    <= '0;
            qneg_q   <= 1'b0;
            rneg_q   <= 1'b0;
            result_q <= '0;
        end else begin
            if (load_i) begin
                rem_q  <= '0;
                quo_q  <= opa_abs_c;
                div_q  <= opb_abs_c;
                qneg_q <= opa_neg_c ^ opb_neg_c;
                rneg_q <= opa_neg_c;
            end else if (step_i) begin
                rem_q <= rem_d;
                quo_q <= quo_d;
            end
            if (load_dbz_i) begin
                result_q <= {opa_i, {WIDTH{1'b1}}};
            end else if (finish_i) begin
                result_q <= {rem_fix_c, quo_fix_c};
            end
        end
    end

    assign result_o = result_q;

endmodule

// File: rtl/div_sequencer.sv
// EX-stage divide sequencer: FSM, iteration counter, pipeline stall and
// one-cycle ready pulse around the restoring-division datapath.
module div_sequencer
    import div_pkg::*;
#(
    parameter int unsigned WIDTH = DIV_ITER
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 startE,
    input  logic                 signedE,
    input  logic                 annulE,
    input  logic [WIDTH-1:0]     opaE,
    input  logic [WIDTH-1:0]     opbE,
    output logic                 stallE,
    output logic                 readyE,
    output logic [2*WIDTH-1:0]   resultE
);

    localparam int unsigned CNT_W = $clog2(WIDTH);

    div_state_t        state_q;
    logic [CNT_W-1:0]  count_q;
    logic              ready_q;

    logic              accept_c;
    logic              divzero_c;
    logic              last_c;
    logic              step_c;
    logic              finish_c;

    // Request acceptance and datapath strobes; annul outranks both start and
    // the final iteration.
    always_comb begin
        accept_c  = startE & ~annulE & (state_q != BUSY);
        divzero_c = (opbE == '0);
        last_c    = (count_q == CNT_W'(WIDTH - 1));
        step_c    = (state_q == BUSY) & ~annulE;
        finish_c  = step_c & last_c;
    end

    // Control FSM with counter and registered ready pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            count_q <= '0;
            ready_q <= 1'b0;
        end else begin
            ready_q <= 1'b0;
            case (state_q)
                BUSY: begin
                    if (annulE) begin
                        state_q <= IDLE;
                        count_q <= '0;
                    end else if (last_c) begin
                        state_q <= DONE;
                        ready_q <= 1'b1;
                        count_q <= '0;
                    end else begin
                        count_q <= count_q + CNT_W'(1);
                    end
                end
                default: begin
                    count_q <= '0;
                    if (accept_c) begin
                        if (divzero_c) begin
                            state_q <= DONE;
                            ready_q <= 1'b1;
                        end else begin
                            state_q <= BUSY;
                        end
                    end else begin
                        state_q <= IDLE;
                    end
                end
            endcase
        end
    end

    // Divide-by-zero never stalls: its result lands one cycle after accept.
    assign stallE = (state_q == BUSY) | (accept_c & ~divzero_c);
    assign readyE = ready_q;

    div_datapath #(
        .WIDTH (WIDTH)
    ) u_datapath (
        .clk        (clk),
        .rst        (rst),
        .load_i     (accept_c & ~divzero_c),
        .load_dbz_i (accept_c & divzero_c),
        .step_i     (step_c),
        .finish_i   (finish_c),
        .signed_i   (signedE),
        .opa_i      (opaE),
        .opb_i      (opbE),
        .result_o   (resultE)
    );

endmodule
